// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, IF/ID output register with a one-entry skid buffer.
// Optional misaligned-PC trap delivery enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
  parameter int unsigned width_p      = 32,
  parameter int unsigned inst_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [width_p-1:0]      pc_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  output logic                    pc_stall_o,
  output logic                    imem_req_valid_o,
  input  logic                    imem_req_ready_i,
  output logic [width_p-1:0]      imem_addr_o,
  input  logic                    imem_resp_valid_i,
  input  logic [inst_width_p-1:0] imem_resp_data_i,
  output logic                    inst_valid_o,
  output logic [inst_width_p-1:0] inst_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic [width_p-1:0]      inst_pc_o,
  output logic                    inst_misaligned_o
`else
  output logic [width_p-1:0]      inst_pc_o
`endif
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [width_p-1:0]      req_pc_q, req_pc_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [inst_width_p-1:0] inst_q, inst_d;
  logic [width_p-1:0]      inst_pc_q, inst_pc_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [inst_width_p-1:0] skid_inst_q, skid_inst_d;
  logic [width_p-1:0]      skid_pc_q, skid_pc_d;

  logic                    req_ok;
  logic                    req_valid;
  logic                    hs;
  logic                    advance;
  logic                    del_valid;
  logic [inst_width_p-1:0] del_inst;
  logic [width_p-1:0]      del_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [inst_width_p-1:0] nop_inst = inst_width_p'(32'h0000_0013);
  logic misaligned_req;
  logic del_mis;
  logic mis_q, mis_d;
  logic skid_mis_q, skid_mis_d;
`endif

  // Request issue and the entry delivered this cycle (memory response or trap NOP).
  always_comb begin
    req_ok    = (state_q == REQ) && !skid_valid_q && !flush_i;
    del_valid = (state_q == WAIT) && imem_resp_valid_i && !flush_i;
    del_inst  = imem_resp_data_i;
    del_pc    = req_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_req = (pc_i[1:0] != 2'b00);
    req_valid      = req_ok && !misaligned_req;
    del_mis        = 1'b0;
    if (req_ok && misaligned_req) begin
      del_valid = 1'b1;
      del_inst  = nop_inst;
      del_pc    = pc_i;
      del_mis   = 1'b1;
    end
    hs      = req_valid && imem_req_ready_i;
    advance = hs || (req_ok && misaligned_req);
`else
    req_valid = req_ok;
    hs        = req_valid && imem_req_ready_i;
    advance   = hs;
`endif
  end

  // Next state, output register and skid buffer.
  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d      = mis_q;
    skid_mis_d = skid_mis_q;
`endif

    case (state_q)
      REQ: begin
        if (hs) begin
          state_d  = WAIT;
          req_pc_d = pc_i;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = imem_resp_valid_i ? REQ : DROP;
        end else if (imem_resp_valid_i) begin
          state_d = REQ;
        end
      end
      DROP: begin
        // A flush without the outstanding response keeps waiting to discard it.
        if (imem_resp_valid_i) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (flush_i) begin
      inst_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!inst_valid_q || !stall_i) begin
      if (skid_valid_q) begin
        inst_valid_d = 1'b1;
        inst_d       = skid_inst_q;
        inst_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d = skid_mis_q;
`endif
      end else if (del_valid) begin
        inst_valid_d = 1'b1;
        inst_d       = del_inst;
        inst_pc_d    = del_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d = del_mis;
`endif
      end else begin
        inst_valid_d = 1'b0;
      end
    end else if (del_valid) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = del_inst;
      skid_pc_d    = del_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      skid_mis_d = del_mis;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= REQ;
      req_pc_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q        <= 1'b0;
      skid_mis_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q        <= mis_d;
      skid_mis_q   <= skid_mis_d;
`endif
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_addr_o      = {pc_i[width_p-1:2], 2'b00};
  assign pc_stall_o       = !advance;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign inst_misaligned_o = mis_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized self-checking bench for instruction_fetch with a behavioural memory/PC model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        stall;
  logic        pc_stall;
  logic        req_valid;
  logic        ready;
  logic [31:0] addr;
  logic        resp_v;
  logic [31:0] resp_d;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        inst_mis;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.width_p(32), .inst_width_p(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pc_i              (pc),
    .flush_i           (flush),
    .stall_i           (stall),
    .pc_stall_o        (pc_stall),
    .imem_req_valid_o  (req_valid),
    .imem_req_ready_i  (ready),
    .imem_addr_o       (addr),
    .imem_resp_valid_i (resp_v),
    .imem_resp_data_i  (resp_d),
    .inst_valid_o      (inst_valid),
    .inst_o            (inst),
`ifdef FETCH_MISALIGN_TRAP_EN
    .inst_pc_o         (inst_pc),
    .inst_misaligned_o (inst_mis)
`else
    .inst_pc_o         (inst_pc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  logic [31:0] pcm, expc, pend_addr;
  bit          pend, prev_wait;
  int          lat, consumed;

  initial begin
    rst = 1'b1; pc = '0; flush = 1'b0; stall = 1'b0; ready = 1'b0;
    resp_v = 1'b0; resp_d = '0;
    #2;
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_inst_pc", inst_pc, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Basic fetch of 0x0 with a 1-cycle memory
    pc = 32'h0; ready = 1'b1; #1;
    chk("t1_req_valid", 32'(req_valid), 32'd1);
    chk("t1_addr", addr, 32'h0);
    chk("t1_hs_pc_stall", 32'(pc_stall), 32'd0);
    tick();
    pc = 32'h4; ready = 1'b0; resp_v = 1'b1; resp_d = 32'h0050_0093; #1;
    chk("t1_wait_req_valid", 32'(req_valid), 32'd0);
    chk("t1_wait_pc_stall", 32'(pc_stall), 32'd1);
    tick();
    resp_v = 1'b0; #1;
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_inst_pc", inst_pc, 32'h0);

    // Memory not ready for 3 cycles
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_req_valid", 32'(req_valid), 32'd1);
      chk("t2_hold_addr", addr, 32'h4);
      chk("t2_hold_pc_stall", 32'(pc_stall), 32'd1);
      tick();
    end
    ready = 1'b1; #1;
    chk("t2_hs_pc_stall", 32'(pc_stall), 32'd0);
    tick();
    pc = 32'h8; ready = 1'b0; resp_v = 1'b1; resp_d = mem_word(32'h4);
    tick();
    resp_v = 1'b0; #1;
    chk("t2_inst_pc", inst_pc, 32'h4);
    chk("t2_inst", inst, mem_word(32'h4));

    // Skid capture while decode stalls
    ready = 1'b1;
    tick();
    pc = 32'hC; resp_v = 1'b1; resp_d = mem_word(32'h8);
    tick();
    resp_v = 1'b0; stall = 1'b1; #1;
    chk("t3_out_pc8", inst_pc, 32'h8);
    chk("t3_req_skid_empty", 32'(req_valid), 32'd1);
    tick();
    pc = 32'h10; resp_v = 1'b1; resp_d = mem_word(32'hC); #1;
    chk("t3_wait_req_valid", 32'(req_valid), 32'd0);
    tick();
    resp_v = 1'b0; #1;
    chk("t3_held_pc", inst_pc, 32'h8);
    chk("t3_held_valid", 32'(inst_valid), 32'd1);
    chk("t3_skid_full_no_req", 32'(req_valid), 32'd0);
    chk("t3_skid_full_pc_stall", 32'(pc_stall), 32'd1);
    tick();
    chk("t3_held_pc_2", inst_pc, 32'h8);
    stall = 1'b0; #1;
    chk("t3_drain_no_req", 32'(req_valid), 32'd0);
    tick();
    chk("t3_drain_pc", inst_pc, 32'hC);
    chk("t3_drain_inst", inst, mem_word(32'hC));
    chk("t3_next_req_valid", 32'(req_valid), 32'd1);
    chk("t3_next_addr", addr, 32'h10);
    tick();
    ready = 1'b0;

    // Flush in WAIT overriding stall; late response discarded
    flush = 1'b1; stall = 1'b1; #1;
    chk("t4_flush_req_valid", 32'(req_valid), 32'd0);
    tick();
    flush = 1'b0; stall = 1'b0; pc = 32'h100; #1;
    chk("t4_flush_cleared", 32'(inst_valid), 32'd0);
    chk("t4_drop_req_valid", 32'(req_valid), 32'd0);
    tick();
    chk("t4_drop_req_valid_2", 32'(req_valid), 32'd0);
    resp_v = 1'b1; resp_d = 32'hDEAD_BEEF;
    tick();
    resp_v = 1'b0; ready = 1'b1; #1;
    chk("t4_discarded", 32'(inst_valid), 32'd0);
    chk("t4_redirect_req", 32'(req_valid), 32'd1);
    chk("t4_redirect_addr", addr, 32'h100);
    tick();
    ready = 1'b0; pc = 32'h104;

    // Flush coincident with response
    flush = 1'b1; resp_v = 1'b1; resp_d = 32'h1234_5678;
    tick();
    flush = 1'b0; resp_v = 1'b0; #1;
    chk("t5_no_entry", 32'(inst_valid), 32'd0);
    chk("t5_back_in_req", 32'(req_valid), 32'd1);
    chk("t5_addr", addr, 32'h104);
    ready = 1'b1;
    tick();
    ready = 1'b0; resp_v = 1'b1; resp_d = mem_word(32'h104);
    tick();
    resp_v = 1'b0; pc = 32'h108; stall = 1'b1; ready = 1'b1;
    chk("t5_inst_pc", inst_pc, 32'h104);
    tick();

    // Asynchronous reset mid-WAIT
    ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_inst", inst, 32'd0);
    chk("t6_rst_inst_pc", inst_pc, 32'd0);
    tick();
    rst = 1'b0; stall = 1'b0; resp_v = 1'b1; resp_d = mem_word(32'h108);
    tick();
    resp_v = 1'b0; #1;
    chk("t6_stray_ignored", 32'(inst_valid), 32'd0);
    chk("t6_in_req", 32'(req_valid), 32'd1);

    // Randomized traffic against a PC/memory/instruction-stream model
    rst = 1'b1; #1 rst = 1'b0;
    pcm = 32'h1000; expc = 32'h1000; pend = 1'b0; lat = 0; pend_addr = '0;
    prev_wait = 1'b0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      flush  = ($urandom_range(0, 31) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      ready  = ($urandom_range(0, 2) != 0);
      pc     = pcm;
      resp_v = pend && (lat == 0);
      resp_d = resp_v ? mem_word(pend_addr) : $urandom;
      #1;
      if (prev_wait && !flush) chk("rnd_no_retract", 32'(req_valid), 32'd1);
      chk("rnd_pc_stall", 32'(pc_stall), 32'(!(req_valid && ready)));
      if (req_valid) begin
        chk("rnd_addr", addr, {pc[31:2], 2'b00});
        chk("rnd_one_outstanding", 32'(pend), 32'd0);
      end
      if (inst_valid && !stall && !flush) begin
        chk("rnd_stream_pc", inst_pc, expc);
        chk("rnd_stream_inst", inst, mem_word(inst_pc));
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rnd_not_misaligned", 32'(inst_mis), 32'd0);
`endif
        expc = expc + 32'd4;
        consumed++;
      end
      if (resp_v) pend = 1'b0;
      else if (pend) lat--;
      if (req_valid && ready) begin
        pend      = 1'b1;
        pend_addr = addr;
        lat       = $urandom_range(0, 2);
      end
      prev_wait = req_valid && !ready;
      if (flush) begin
        pcm  = {16'h0, 14'($urandom), 2'b00};
        expc = pcm;
      end else if (!pc_stall) begin
        pcm = pcm + 32'd4;
      end
      tick();
    end
    flush = 1'b0; stall = 1'b0; resp_v = 1'b0;
    chk("rnd_progress", 32'(consumed > 200), 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    rst = 1'b1; #1 rst = 1'b0;
    pc = 32'h6; ready = 1'b1; #1;
    chk("mis_no_req", 32'(req_valid), 32'd0);
    chk("mis_pc_stall", 32'(pc_stall), 32'd0);
    tick();
    pc = 32'h8; ready = 1'b0; #1;
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_inst", inst, 32'h0000_0013);
    chk("mis_pc", inst_pc, 32'h6);
    chk("mis_flag", 32'(inst_mis), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
